uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;
  localparam int DATA_W  = 8;
  localparam int GRANT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index after ptr, wrapping modulo NREQ.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]    valid_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] idx_o,
  output logic               any_o
);

  logic [3:0]         validPad;
  logic [GRANT_W-1:0] cand;

  // Padding to four entries keeps the variable index the same width for every NREQ.
  always_comb begin
    validPad = '0;
    validPad[NREQ-1:0] = valid_i;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GRANT_W'((int'(ptr_i) + i) % NREQ);
      if (!any_o && validPad[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters, granting whole frames
// round-robin and dropping an owner that stalls mid-frame for LOCK_TO cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int LOCK_TO = 1023
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [DATA_W*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]        req_last_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   tx_start_o,
  output logic [DATA_W-1:0]      tx_data_o,
  input  logic                   tx_busy_i,
  output logic [GRANT_W-1:0]     grant_o,
  output logic                   active_o,
  output logic                   abort_o
);

  localparam int               CNT_W    = $clog2(LOCK_TO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TO - 1);

  state_e             state_q;
  logic [GRANT_W-1:0] owner_q;
  logic [GRANT_W-1:0] ptr_q;
  logic [DATA_W-1:0]  txData_q;
  logic               lastFlag_q;
  logic               start_q;
  logic               abort_q;
  logic [CNT_W-1:0]   lockCnt_q;

  logic [GRANT_W-1:0] pickIdx;
  logic               pickAny;
  logic               ownerValid;
  logic               ownerLast;
  logic [DATA_W-1:0]  ownerData;
  logic               accept;

  rr_picker #(
    .NREQ(NREQ)
  ) picker (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .idx_o  (pickIdx),
    .any_o  (pickAny)
  );

  // Only the owner's lines are ever looked at, so non-owner activity cannot disturb a frame.
  always_comb begin
    ownerValid = 1'b0;
    ownerLast  = 1'b0;
    ownerData  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == GRANT_W'(k)) begin
        ownerValid = req_valid_i[k];
        ownerLast  = req_last_i[k];
        ownerData  = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = (state_q == SEND) && ownerValid && !tx_busy_i;

  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready_o[k] = accept && (owner_q == GRANT_W'(k));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= GRANT_W'(NREQ - 1);
      txData_q   <= '0;
      lastFlag_q <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      lockCnt_q  <= '0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickAny) begin
            owner_q <= pickIdx;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            txData_q   <= ownerData;
            lastFlag_q <= ownerLast;
            start_q    <= 1'b1;
            lockCnt_q  <= '0;
            state_q    <= WAIT_ACK;
          end else if (!ownerValid) begin
            // A busy transmitter is not the owner's fault, so only missing data counts.
            if (lockCnt_q == CNT_LAST) begin
              abort_q   <= 1'b1;
              ptr_q     <= owner_q;
              lockCnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              lockCnt_q <= lockCnt_q + 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            if (lastFlag_q) begin
              ptr_q   <= owner_q;
              state_q <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start_o = start_q;
  assign tx_data_o  = txData_q;
  assign grant_o    = owner_q;
  assign active_o   = (state_q != IDLE);
  assign abort_o    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers, a transmitter model,
// a frame-level round-robin reference and a monitor that checks every start pulse.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ    = 3;
  localparam int LOCK_TO = 15;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } item_t;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   reqValid;
  logic [8*NREQ-1:0] reqData;
  logic [NREQ-1:0]   reqLast;
  logic [NREQ-1:0]   reqReady;
  logic              txStart;
  logic [7:0]        txData;
  logic              txBusy;
  logic [1:0]        grant;
  logic              active;
  logic              abort;

  item_t pendQ[NREQ][$];
  exp_t  expQ[$];
  int    startCycles[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int abortCnt = 0;
  int acceptCnt = 0;
  int lockOwner = -1;
  int dropCnt[NREQ];
  bit stallForever[NREQ];
  bit stallAfterFirst[NREQ];
  bit enableDrops = 0;
  bit busyRand = 0;
  bit txRespond = 1;
  int busyLen = 2;
  logic [NREQ-1:0] readyNeg = '0;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .LOCK_TO(LOCK_TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(reqValid),
    .req_data_i (reqData),
    .req_last_i (reqLast),
    .req_ready_o(reqReady),
    .tx_start_o (txStart),
    .tx_data_o  (txData),
    .tx_busy_i  (txBusy),
    .grant_o    (grant),
    .active_o   (active),
    .abort_o    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] data, input bit last);
    item_t it;
    it.data = data;
    it.last = last;
    pendQ[k].push_back(it);
  endtask

  task automatic expectTx(input int owner, input logic [7:0] data);
    exp_t e;
    e.owner = 2'(owner);
    e.data  = data;
    expQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_grant"}, int'(grant), 0);
    checkOutput({tag, "_tx_data"}, int'(txData), 0);
    checkOutput({tag, "_tx_start"}, int'(txStart), 0);
    checkOutput({tag, "_ready"}, int'(reqReady), 0);
    checkOutput({tag, "_active"}, int'(active), 0);
    checkOutput({tag, "_abort"}, int'(abort), 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      pendQ[k].delete();
      stallForever[k] = 1'b0;
      stallAfterFirst[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int maxCyc);
    int n = 0;
    while ((expQ.size() != 0 || active) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, (n < maxCyc) ? 1 : 0, 1);
    expQ.delete();
  endtask

  // Requester drivers: present the queue head, pop it on acceptance, optionally stall mid-frame.
  initial begin
    item_t it;
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;
    for (int k = 0; k < NREQ; k++) dropCnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (readyNeg[k] && !rst && pendQ[k].size() > 0) begin
          it = pendQ[k].pop_front();
          if (!it.last) begin
            if (stallAfterFirst[k]) stallForever[k] = 1'b1;
            else if (enableDrops) dropCnt[k] = $urandom_range(0, 4);
          end
        end
        if (stallForever[k]) begin
          reqValid[k] = 1'b0;
        end else if (dropCnt[k] > 0) begin
          reqValid[k] = 1'b0;
          dropCnt[k]--;
        end else begin
          reqValid[k] = (pendQ[k].size() > 0);
        end
        if (pendQ[k].size() > 0) begin
          reqData[k*8 +: 8] = pendQ[k][0].data;
          reqLast[k] = pendQ[k][0].last;
        end
      end
    end
  end

  // Transmitter model: raises busy right after a start pulse and holds it for a while.
  initial begin
    int len;
    txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (txStart && txRespond && !rst) begin
        txBusy = 1'b1;
        len = busyRand ? int'($urandom_range(1, 6)) : busyLen;
        repeat (len) @(posedge clk);
        #1;
        txBusy = 1'b0;
      end
    end
  end

  // Monitor: every start must follow an accept by one cycle and match the scoreboard head.
  initial begin
    bit prevAcc = 0;
    logic [7:0] prevByte = '0;
    exp_t e;
    int k;
    int nSet;
    forever begin
      @(negedge clk);
      cyc++;
      readyNeg = reqReady;
      if (rst) begin
        prevAcc = 0;
        lockOwner = -1;
      end else begin
        if (txStart || prevAcc) checkOutput("start_after_accept", int'(txStart), int'(prevAcc));
        if (txStart) begin
          startCycles.push_back(cyc);
          if (prevAcc) checkOutput("tx_data_is_accepted", int'(txData), int'(prevByte));
          if (expQ.size() == 0) begin
            checkOutput("unexpected_start", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("tx_data", int'(txData), int'(e.data));
            checkOutput("grant", int'(grant), int'(e.owner));
          end
        end
        prevAcc = 0;
        if (reqReady != '0) begin
          k = 0;
          nSet = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (reqReady[i]) begin
              k = i;
              nSet++;
            end
          end
          checkOutput("ready_legal", (nSet == 1 && reqValid[k] && !txBusy && active) ? 1 : 0, 1);
          if (lockOwner >= 0) checkOutput("frame_lock", k, lockOwner);
          lockOwner = reqLast[k] ? -1 : k;
          acceptCnt++;
          prevAcc  = 1;
          prevByte = reqData[k*8 +: 8];
        end
        if (abort) begin
          abortCnt++;
          lockOwner = -1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    int ptr;
    int cand;
    int lens[NREQ][$];
    logic [7:0] genBytes[NREQ][$];
    logic [7:0] b;
    int len;
    bit any;

    rst = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      stallForever[k] = 1'b0;
      stallAfterFirst[k] = 1'b0;
    end
    resetDut();

    // Three simultaneous single-byte frames rotate 0,1,2 from reset.
    $display("[TB] scenario: simultaneous requesters");
    @(negedge clk);
    applyStimulus(0, 8'h41, 1);
    applyStimulus(1, 8'h42, 1);
    applyStimulus(2, 8'h43, 1);
    expectTx(0, 8'h41);
    expectTx(1, 8'h42);
    expectTx(2, 8'h43);
    waitDrain("simultaneous", 200);

    // A granted three-byte frame finishes before a later contender gets a byte.
    $display("[TB] scenario: frame lock");
    resetDut();
    applyStimulus(1, 8'h10, 0);
    applyStimulus(1, 8'h11, 0);
    applyStimulus(1, 8'h12, 1);
    expectTx(1, 8'h10);
    expectTx(1, 8'h11);
    expectTx(1, 8'h12);
    expectTx(0, 8'h20);
    repeat (3) @(negedge clk);
    applyStimulus(0, 8'h20, 1);
    waitDrain("frame_lock", 300);

    // A long busy period holds off both ready and the next start.
    $display("[TB] scenario: long busy");
    resetDut();
    busyLen = 20;
    startCycles.delete();
    applyStimulus(0, 8'h55, 1);
    applyStimulus(0, 8'h66, 1);
    expectTx(0, 8'h55);
    expectTx(0, 8'h66);
    waitDrain("long_busy", 300);
    checkOutput("long_busy_starts", startCycles.size(), 2);
    if (startCycles.size() == 2)
      checkOutput("long_busy_gap", startCycles[1] - startCycles[0], 20 + 3);

    // Owner stalls after its first byte and is dropped after LOCK_TO stall cycles.
    $display("[TB] scenario: timeout abort");
    resetDut();
    busyLen = 2;
    base = abortCnt;
    stallAfterFirst[0] = 1'b1;
    applyStimulus(0, 8'hA1, 0);
    applyStimulus(0, 8'hA2, 1);
    applyStimulus(1, 8'hB1, 1);
    expectTx(0, 8'hA1);
    expectTx(1, 8'hB1);
    n = 0;
    while (!txBusy && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (txBusy && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!abort && n < 100) begin
      @(negedge clk);
      if (!abort) n++;
    end
    checkOutput("abort_stall_cycles", n, LOCK_TO);
    pendQ[0].delete();
    stallForever[0] = 1'b0;
    stallAfterFirst[0] = 1'b0;
    @(negedge clk);
    checkOutput("abort_is_pulse", int'(abort), 0);
    waitDrain("abort", 200);
    checkOutput("abort_count", abortCnt - base, 1);

    // Reset while waiting for busy discards the frame; nothing starts afterwards.
    $display("[TB] scenario: reset in WAIT_ACK");
    resetDut();
    txRespond = 1'b0;
    applyStimulus(0, 8'h77, 0);
    applyStimulus(0, 8'h78, 1);
    expectTx(0, 8'h77);
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_ack_reached", (n < 100) ? 1 : 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("mid_reset");
    for (int k = 0; k < NREQ; k++) pendQ[k].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txRespond = 1'b1;
    startCycles.delete();
    repeat (12) @(negedge clk);
    checkOutput("no_start_after_reset", startCycles.size(), 0);
    checkOutput("idle_after_reset", int'(active), 0);

    // A lone requester gets back-to-back frames with one idle cycle between them.
    $display("[TB] scenario: lone requester");
    resetDut();
    busyLen = 1;
    base = acceptCnt;
    startCycles.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'h90 + 8'(i);
      applyStimulus(2, b, 1);
      expectTx(2, b);
    end
    waitDrain("lone", 300);
    checkOutput("lone_accepts", acceptCnt - base, 4);
    checkOutput("lone_starts", startCycles.size(), 4);
    for (int i = 1; i < startCycles.size(); i++)
      checkOutput("lone_gap", startCycles[i] - startCycles[i-1], 1 + 3);

    // Random frames from all requesters with random stalls and transmitter timing.
    $display("[TB] scenario: random traffic");
    resetDut();
    busyRand = 1'b1;
    enableDrops = 1'b1;
    base = abortCnt;
    for (int k = 0; k < NREQ; k++) begin
      for (int f = 0; f < 4; f++) begin
        len = $urandom_range(1, 3);
        lens[k].push_back(len);
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom);
          genBytes[k].push_back(b);
          applyStimulus(k, b, j == len - 1);
        end
      end
    end
    ptr = NREQ - 1;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      cand = 0;
      for (int i = 1; i <= NREQ; i++) begin
        if (!any && lens[(ptr + i) % NREQ].size() > 0) begin
          cand = (ptr + i) % NREQ;
          any = 1'b1;
        end
      end
      if (any) begin
        len = lens[cand].pop_front();
        for (int j = 0; j < len; j++) expectTx(cand, genBytes[cand].pop_front());
        ptr = cand;
      end
    end
    waitDrain("random", 3000);
    checkOutput("random_no_abort", abortCnt - base, 0);
    busyRand = 1'b0;
    enableDrops = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
